// File: rtl/half_adder_bist.sv
// Built-in self-test engine for a half adder: sweeps {a,b}, checks sum/carry,
// and reports pass/fail, a saturating error count and the first failing vector.
module half_adder_bist #(
    parameter int PASSES  = 1,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             sum_i,
    input  logic             carry_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail,
    output logic             fail_seen
);

    localparam int N  = 4 * PASSES;
    localparam int IW = $clog2(N);
    localparam int DW = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                    state;
    logic [IW-1:0]             idx;
    logic [DW-1:0]             dcnt;
    logic [DUT_LAT:0]          vld_q;
    logic [DUT_LAT:0][1:0]     ix_q;
    logic [DUT_LAT:0][1:0]     exp_q;

    logic             mism;
    logic [ERR_W-1:0] err_nxt;
    logic [IW-1:0]    idx_nxt;

    // Stage DUT_LAT of the expected-value pipe lines up with the DUT output.
    assign mism    = vld_q[DUT_LAT] && ({sum_i, carry_i} != exp_q[DUT_LAT]);
    assign err_nxt = (mism && (err_count != '1)) ? err_count + 1'b1 : err_count;
    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            dcnt       <= '0;
            vld_q      <= '0;
            ix_q       <= '0;
            exp_q      <= '0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= 2'b00;
            fail_seen  <= 1'b0;
        end else begin
            for (int k = DUT_LAT; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
                ix_q[k]  <= ix_q[k-1];
                exp_q[k] <= exp_q[k-1];
            end
            vld_q[0]   <= 1'b0;
            ix_q[0]    <= 2'b00;
            exp_q[0]   <= 2'b00;
            {a_o, b_o} <= 2'b00;

            if (mism) begin
                err_count <= err_nxt;
                fail_seen <= 1'b1;
                if (!fail_seen) begin
                    first_fail <= ix_q[DUT_LAT];
                end
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= 2'b00;
                        fail_seen  <= 1'b0;
                        idx        <= '0;
                        vld_q[0]   <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx == IW'(N - 1)) begin
                        if (DUT_LAT > 0) begin
                            state <= DRAIN;
                            dcnt  <= DW'(1);
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end
                    end else begin
                        idx        <= idx_nxt;
                        {a_o, b_o} <= idx_nxt[1:0];
                        vld_q[0]   <= 1'b1;
                        ix_q[0]    <= idx_nxt[1:0];
                        exp_q[0]   <= {idx_nxt[1] ^ idx_nxt[0],
                                       idx_nxt[1] & idx_nxt[0]};
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DUT_LAT)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_adder_bist.sv
// Bench for half_adder_bist: three engines (combinational, 8-pass, 2-flop DUT)
// driving half-adder models with per-vector fault masks.
module tb_half_adder_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       st = '0;
    logic [2:0]       a, b, s, c, bz, dn, ps, fs;
    logic [2:0][3:0]  ec;
    logic [2:0][1:0]  ff;
    // Per-instance, per-vector xor mask on {sum,carry}.
    logic [2:0][3:0][1:0] mk = '0;
    logic [1:0] r0 = '0, r1 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    assign s[0] = (a[0] ^ b[0]) ^ mk[0][{a[0], b[0]}][1];
    assign c[0] = (a[0] & b[0]) ^ mk[0][{a[0], b[0]}][0];
    assign s[1] = (a[1] ^ b[1]) ^ mk[1][{a[1], b[1]}][1];
    assign c[1] = (a[1] & b[1]) ^ mk[1][{a[1], b[1]}][0];

    always_ff @(posedge clk) begin
        r0 <= {a[2] ^ b[2], a[2] & b[2]} ^ mk[2][{a[2], b[2]}];
        r1 <= r0;
    end
    assign s[2] = r1[1];
    assign c[2] = r1[0];

    half_adder_bist #(.PASSES(1), .DUT_LAT(0), .ERR_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a_o(a[0]), .b_o(b[0]),
        .sum_i(s[0]), .carry_i(c[0]), .busy(bz[0]), .done(dn[0]),
        .pass(ps[0]), .err_count(ec[0]), .first_fail(ff[0]),
        .fail_seen(fs[0]));

    half_adder_bist #(.PASSES(8), .DUT_LAT(0), .ERR_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a_o(a[1]), .b_o(b[1]),
        .sum_i(s[1]), .carry_i(c[1]), .busy(bz[1]), .done(dn[1]),
        .pass(ps[1]), .err_count(ec[1]), .first_fail(ff[1]),
        .fail_seen(fs[1]));

    half_adder_bist #(.PASSES(1), .DUT_LAT(2), .ERR_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a_o(a[2]), .b_o(b[2]),
        .sum_i(s[2]), .carry_i(c[2]), .busy(bz[2]), .done(dn[2]),
        .pass(ps[2]), .err_count(ec[2]), .first_fail(ff[2]),
        .fail_seen(fs[2]));

    function automatic int passes_of(input int k);
        return (k == 1) ? 8 : 1;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 2) ? 2 : 0;
    endfunction

    // Pulse start on instance k; lat = edges from the start edge to done, -1 on timeout.
    task automatic run_to_done(input int k, output int lat);
        lat = -1;
        @(posedge clk); #1 st[k] = 1'b1;
        @(posedge clk); #1 st[k] = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (dn[k]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({a[k], b[k], bz[k], dn[k], ps[k], fs[k], ec[k], ff[k]} !== 12'h0) begin
                n_bad++;
                $display("FAIL reset_state inst%0d: got %h expected 0", k,
                         {a[k], b[k], bz[k], dn[k], ps[k], fs[k], ec[k], ff[k]});
            end
        end
    endtask

    task automatic test_sequence;
        mk[0] = '0;
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if ({a[0], b[0], bz[0], dn[0]} !== {j[1:0], 2'b10}) begin
                n_bad++;
                $display("FAIL sequence vec%0d: got %b expected %b", j,
                         {a[0], b[0], bz[0], dn[0]}, {j[1:0], 2'b10});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({dn[0], bz[0], ps[0], fs[0], ec[0]} !== 8'b1010_0000) begin
            n_bad++;
            $display("FAIL sequence_done: got %b expected 10100000",
                     {dn[0], bz[0], ps[0], fs[0], ec[0]});
        end
    endtask

    task automatic test_stuck_carry;
        int lat;
        mk[0] = {2'b00, 2'b01, 2'b01, 2'b01};
        run_to_done(0, lat);
        n_cmp++;
        if (lat != 4 || ec[0] !== 4'd3 || ff[0] !== 2'd0 || fs[0] !== 1'b1 || ps[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_carry: got lat=%0d err=%0d ff=%0d fs=%b pass=%b expected lat=4 err=3 ff=0 fs=1 pass=0",
                     lat, ec[0], ff[0], fs[0], ps[0]);
        end
    endtask

    task automatic test_saturate;
        int lat;
        mk[1] = {4{2'b10}};
        run_to_done(1, lat);
        n_cmp++;
        if (lat != 32 || ec[1] !== 4'd15 || ff[1] !== 2'd0 || ps[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL saturate: got lat=%0d err=%0d ff=%0d pass=%b expected lat=32 err=15 ff=0 pass=0",
                     lat, ec[1], ff[1], ps[1]);
        end
        mk[1] = '0;
    endtask

    task automatic test_drain;
        int lat;
        mk[2] = '0;
        @(posedge clk); #1 st[2] = 1'b1;
        @(posedge clk); #1 st[2] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            logic [1:0] v;
            v = (j < 4) ? 2'(j) : 2'b00;
            n_cmp++;
            if ({a[2], b[2], bz[2], dn[2]} !== {v, 2'b10}) begin
                n_bad++;
                $display("FAIL drain cyc%0d: got %b expected %b", j,
                         {a[2], b[2], bz[2], dn[2]}, {v, 2'b10});
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({dn[2], bz[2], ps[2], ec[2]} !== 7'b101_0000) begin
            n_bad++;
            $display("FAIL drain_done: got %b expected 1010000",
                     {dn[2], bz[2], ps[2], ec[2]});
        end
        mk[2][3] = 2'b10;
        run_to_done(2, lat);
        n_cmp++;
        if (lat != 6 || ec[2] !== 4'd1 || ff[2] !== 2'd3 || ps[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_sum11: got lat=%0d err=%0d ff=%0d pass=%b expected lat=6 err=1 ff=3 pass=0",
                     lat, ec[2], ff[2], ps[2]);
        end
        mk[2] = '0;
    endtask

    task automatic test_start_held;
        int lat = -1;
        mk[0] = {2'b01, 2'b00, 2'b00, 2'b00};
        @(posedge clk); #1 st[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (dn[0]) begin
                lat = i - 1;
                break;
            end
        end
        st[0] = 1'b0;
        n_cmp++;
        if (lat != 4 || ec[0] !== 4'd1 || ff[0] !== 2'd3) begin
            n_bad++;
            $display("FAIL start_held: got lat=%0d err=%0d ff=%0d expected lat=4 err=1 ff=3",
                     lat, ec[0], ff[0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (dn[0] !== 1'b1 || bz[0] !== 1'b0 || ec[0] !== 4'd1) begin
            n_bad++;
            $display("FAIL done_held: got done=%b busy=%b err=%0d expected 1 0 1",
                     dn[0], bz[0], ec[0]);
        end
    endtask

    task automatic test_restart;
        int lat;
        mk[0] = {2'b00, 2'b01, 2'b01, 2'b01};
        run_to_done(0, lat);
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        n_cmp++;
        if ({dn[0], bz[0], fs[0], ec[0], a[0], b[0]} !== 9'b010_0000_00) begin
            n_bad++;
            $display("FAIL restart: got %b expected 010000000",
                     {dn[0], bz[0], fs[0], ec[0], a[0], b[0]});
        end
        for (int i = 0; i < 10 && !dn[0]; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dn[0] !== 1'b1 || ec[0] !== 4'd3) begin
            n_bad++;
            $display("FAIL restart_result: got done=%b err=%0d expected 1 3", dn[0], ec[0]);
        end
    endtask

    task automatic test_reset_midrun;
        mk[0] = {4{2'b10}};
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a[0], b[0], bz[0], dn[0], ps[0], fs[0], ec[0], ff[0]} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_midrun: got %h expected 0",
                     {a[0], b[0], bz[0], dn[0], ps[0], fs[0], ec[0], ff[0]});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dn[0] !== 1'b0 || bz[0] !== 1'b0 || ec[0] !== 4'd0) begin
            n_bad++;
            $display("FAIL after_reset: got done=%b busy=%b err=%0d expected 0 0 0",
                     dn[0], bz[0], ec[0]);
        end
        mk[0] = '0;
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            int k, lat, nz, errs, ffx, lat_x;
            k = $urandom_range(0, 2);
            nz = 0;
            ffx = -1;
            for (int v = 0; v < 4; v++) begin
                mk[k][v] = 2'($urandom_range(0, 3));
                if (mk[k][v] != 2'b00) begin
                    nz++;
                    if (ffx < 0) ffx = v;
                end
            end
            if (ffx < 0) ffx = 0;
            errs = nz * passes_of(k);
            if (errs > 15) errs = 15;
            lat_x = 4 * passes_of(k) + lat_of(k);
            run_to_done(k, lat);
            n_cmp++;
            if (lat != lat_x || ec[k] !== 4'(errs) || ff[k] !== 2'(ffx) ||
                fs[k] !== (nz != 0) || ps[k] !== (nz == 0)) begin
                n_bad++;
                $display("FAIL random it%0d inst%0d: got lat=%0d err=%0d ff=%0d fs=%b pass=%b expected lat=%0d err=%0d ff=%0d fs=%b pass=%b",
                         it, k, lat, ec[k], ff[k], fs[k], ps[k],
                         lat_x, errs, ffx, nz != 0, nz == 0);
            end
            mk[k] = '0;
        end
    endtask

    initial begin
        #22 test_reset;
        @(negedge clk) rst_n = 1'b1;
        test_sequence;
        test_stuck_carry;
        test_saturate;
        test_drain;
        test_start_held;
        test_restart;
        test_reset_midrun;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
